// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage_pkg
//  Description : Shared widths, write-back select encodings, FSM state type
//                and write-back mux helper for the MEM/WB pipeline stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_wb_stage_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 19;
    localparam int RD_W    = 3;

    // Write-back source select; 2'b11 aliases the ALU path.
    localparam logic [1:0] WB_ALU   = 2'b00;
    localparam logic [1:0] WB_MEM   = 2'b01;
    localparam logic [1:0] WB_SHIFT = 2'b10;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    function automatic logic [DATA_W-1:0] wb_select(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] shift
    );
        logic [DATA_W-1:0] v;
        case (sel)
            WB_MEM:   v = mem;
            WB_SHIFT: v = shift;
            default:  v = alu;
        endcase
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_data_mem.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem
//  Description : 256x8 data memory, one synchronous write port and one
//                asynchronous read port. Contents are not reset; the owning
//                stage clears it with an explicit write sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem
    import mem_wb_stage_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    // Single write port, committed at the rising edge.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/ms_dff.sv
`default_nettype none
// ============================================================================
//  Module      : ms_dff
//  Description : Master-slave (edge-triggered) register primitive with a
//                synchronous active-high reset to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module ms_dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Capture d on every rising edge, clearing synchronously on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= '0;
        end else begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_wb_stage
//  Description : Memory access and MEM/WB pipeline register. After reset an
//                optional 256-cycle sequence zeroes the data memory while
//                stalling upstream; afterwards stores/loads run normally and
//                the selected write-back value is forwarded and registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int CLEAR_ON_RESET = 1,
    parameter int RD_LSB         = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [DATA_W-1:0]  EX_MEM_alu_out,
    input  logic [DATA_W-1:0]  EX_MEM_B,
    input  logic [DATA_W-1:0]  EX_MEM_shift_out,
    input  logic               EX_MEM_mem_write,
    input  logic               EX_MEM_reg_write,
    input  logic [INSTR_W-1:0] EX_MEM_instruction,
    input  logic [1:0]         EX_MEM_reg_write_mux,
    output logic [DATA_W-1:0]  MEM_WB_wb_data,
    output logic [RD_W-1:0]    MEM_WB_rd,
    output logic               MEM_WB_reg_write,
    output logic [INSTR_W-1:0] MEM_WB_instruction,
    output logic [DATA_W-1:0]  fwd_data,
    output logic [RD_W-1:0]    fwd_rd,
    output logic               fwd_valid,
    output logic               mem_busy
);

    localparam int C_REG_W = DATA_W + RD_W + 1 + INSTR_W;

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_cnt;

    logic              w_clearing;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;
    logic [DATA_W-1:0] w_mem_rdata;
    logic [DATA_W-1:0] w_wb_data;
    logic [RD_W-1:0]   w_rd;
    logic              w_reg_write;
    logic [C_REG_W-1:0] w_reg_d;
    logic [C_REG_W-1:0] w_reg_q;

    // Clear/run sequencer: walk every address once, then leave clearing
    // through the state change so the counter never wraps on its own.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == {ADDR_W{1'b1}}) begin
                        r_state   <= ST_RUN;
                        r_clr_cnt <= '0;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign w_clearing = (r_state == ST_CLEAR);
    assign mem_busy   = w_clearing;

    // While clearing, the write port belongs to the sequencer and pipeline
    // stores are dropped; stores are also held off while reset is asserted.
    assign w_mem_we    = w_clearing ? 1'b1 : (EX_MEM_mem_write & ~reset);
    assign w_mem_waddr = w_clearing ? r_clr_cnt : EX_MEM_alu_out;
    assign w_mem_wdata = w_clearing ? '0 : EX_MEM_B;

    data_mem u_data_mem (
        .clk     (clk),
        .i_we    (w_mem_we),
        .i_waddr (w_mem_waddr),
        .i_wdata (w_mem_wdata),
        .i_raddr (EX_MEM_alu_out),
        .o_rdata (w_mem_rdata)
    );

    assign w_wb_data   = wb_select(EX_MEM_reg_write_mux, EX_MEM_alu_out,
                                   w_mem_rdata, EX_MEM_shift_out);
    assign w_rd        = EX_MEM_instruction[RD_LSB+RD_W-1:RD_LSB];
    // A clearing cycle is a bubble: no register write leaves this stage.
    assign w_reg_write = EX_MEM_reg_write & ~w_clearing;

    assign fwd_data  = w_wb_data;
    assign fwd_rd    = w_rd;
    assign fwd_valid = w_reg_write;

    assign w_reg_d = {w_wb_data, w_rd, w_reg_write, EX_MEM_instruction};

    ms_dff #(
        .WIDTH (C_REG_W)
    ) u_mem_wb_reg (
        .clk (clk),
        .rst (reset),
        .i_d (w_reg_d),
        .o_q (w_reg_q)
    );

    assign {MEM_WB_wb_data, MEM_WB_rd, MEM_WB_reg_write, MEM_WB_instruction} = w_reg_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_wb_stage
//  Description : Self-checking bench for mem_wb_stage. Expected MEM/WB
//                register contents are pushed to a scoreboard when stimulus
//                is applied and popped after the capturing edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  EX_MEM_alu_out = '0;
    logic [7:0]  EX_MEM_B = '0;
    logic [7:0]  EX_MEM_shift_out = '0;
    logic        EX_MEM_mem_write = 1'b0;
    logic        EX_MEM_reg_write = 1'b0;
    logic [18:0] EX_MEM_instruction = '0;
    logic [1:0]  EX_MEM_reg_write_mux = '0;
    logic [7:0]  MEM_WB_wb_data;
    logic [2:0]  MEM_WB_rd;
    logic        MEM_WB_reg_write;
    logic [18:0] MEM_WB_instruction;
    logic [7:0]  fwd_data;
    logic [2:0]  fwd_rd;
    logic        fwd_valid;
    logic        mem_busy;

    always #5 clk = ~clk;

    mem_wb_stage #(
        .CLEAR_ON_RESET (1),
        .RD_LSB         (11)
    ) dut (
        .clk                  (clk),
        .reset                (reset),
        .EX_MEM_alu_out       (EX_MEM_alu_out),
        .EX_MEM_B             (EX_MEM_B),
        .EX_MEM_shift_out     (EX_MEM_shift_out),
        .EX_MEM_mem_write     (EX_MEM_mem_write),
        .EX_MEM_reg_write     (EX_MEM_reg_write),
        .EX_MEM_instruction   (EX_MEM_instruction),
        .EX_MEM_reg_write_mux (EX_MEM_reg_write_mux),
        .MEM_WB_wb_data       (MEM_WB_wb_data),
        .MEM_WB_rd            (MEM_WB_rd),
        .MEM_WB_reg_write     (MEM_WB_reg_write),
        .MEM_WB_instruction   (MEM_WB_instruction),
        .fwd_data             (fwd_data),
        .fwd_rd               (fwd_rd),
        .fwd_valid            (fwd_valid),
        .mem_busy             (mem_busy)
    );

    typedef struct packed {
        logic [7:0]  d;
        logic [2:0]  rd;
        logic        we;
        logic [18:0] ins;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  model_mem [0:255];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [30:0] obs;

    assign obs = {MEM_WB_wb_data, MEM_WB_rd, MEM_WB_reg_write, MEM_WB_instruction};

    // An empty scoreboard yields all-X so the following compare fails.
    function automatic exp_t pop_exp();
        exp_t e;
        e = 'x;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        EX_MEM_alu_out       = '0;
        EX_MEM_B             = '0;
        EX_MEM_shift_out     = '0;
        EX_MEM_mem_write     = 1'b0;
        EX_MEM_reg_write     = 1'b0;
        EX_MEM_instruction   = '0;
        EX_MEM_reg_write_mux = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 256; i++) model_mem[i] = 8'h00;
    endtask

    // Drive one RUN-mode transaction and record what MEM/WB must hold next.
    task automatic apply(input logic [7:0] alu, input logic [7:0] b,
                         input logic [7:0] sh, input logic mw, input logic rw,
                         input logic [1:0] sel, input logic [2:0] rd);
        logic [18:0] ins;
        logic [7:0]  v;
        exp_t        e;
        ins        = 19'($urandom);
        ins[13:11] = rd;
        EX_MEM_alu_out       = alu;
        EX_MEM_B             = b;
        EX_MEM_shift_out     = sh;
        EX_MEM_mem_write     = mw;
        EX_MEM_reg_write     = rw;
        EX_MEM_instruction   = ins;
        EX_MEM_reg_write_mux = sel;
        case (sel)
            2'b01:   v = model_mem[alu];
            2'b10:   v = sh;
            default: v = alu;
        endcase
        e.d = v; e.rd = rd; e.we = rw; e.ins = ins;
        sb.push_back(e);
        if (mw) model_mem[alu] = b;
        #1;
    endtask

    task automatic test_reset();
        int   cnt;
        logic bad;
        exp_t e;
        idle();
        EX_MEM_alu_out     = 8'h80;
        EX_MEM_B           = 8'hAA;
        EX_MEM_mem_write   = 1'b1;
        EX_MEM_reg_write   = 1'b1;
        EX_MEM_instruction = 19'h3FFFF;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs !== 31'd0) begin
            n_fails++; $display("FAIL reset_regs: got %h want 0", obs);
        end
        n_checks++;
        if (mem_busy !== 1'b1) begin
            n_fails++; $display("FAIL reset_busy: got %b want 1", mem_busy);
        end
        cnt = 0; bad = 1'b0;
        while (mem_busy === 1'b1 && cnt < 400) begin
            if (MEM_WB_reg_write !== 1'b0 || fwd_valid !== 1'b0) bad = 1'b1;
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 256) begin
            n_fails++; $display("FAIL clear_len: got %0d cycles want 256", cnt);
        end
        n_checks++;
        if (bad !== 1'b0) begin
            n_fails++; $display("FAIL clear_bubble: reg_write/fwd_valid seen high got %b want 0", bad);
        end
        model_clear();
        idle();
        apply(8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 3'd2);
        n_checks++;
        if (fwd_data !== 8'h00 || fwd_valid !== 1'b1) begin
            n_fails++; $display("FAIL load_ff_fwd: got %h/%b want 00/1", fwd_data, fwd_valid);
        end
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL load_ff_reg: got %h want %h", obs, e);
        end
    endtask

    task automatic test_clear_store_ignored();
        exp_t e;
        apply(8'h80, 8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 3'd4);
        n_checks++;
        if (fwd_data !== 8'h00) begin
            n_fails++; $display("FAIL clear_store_fwd: got %h want 00", fwd_data);
        end
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL clear_store_reg: got %h want %h", obs, e);
        end
    endtask

    task automatic test_store_load();
        exp_t e;
        apply(8'h10, 8'h5A, 8'h00, 1'b1, 1'b0, 2'b00, 3'd1);
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL store_reg: got %h want %h", obs, e);
        end
        apply(8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 3'd3);
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL load_reg: got %h want %h", obs, e);
        end
        n_checks++;
        if ({MEM_WB_wb_data, MEM_WB_rd, MEM_WB_reg_write} !== {8'h5A, 3'd3, 1'b1}) begin
            n_fails++; $display("FAIL load_fields: got %h/%0d/%b want 5a/3/1",
                                MEM_WB_wb_data, MEM_WB_rd, MEM_WB_reg_write);
        end
    endtask

    task automatic test_mux_sweep();
        exp_t       e;
        logic [7:0] exp_tab [4];
        exp_tab = '{8'h11, 8'h33, 8'h22, 8'h11};
        apply(8'h11, 8'h33, 8'h00, 1'b1, 1'b0, 2'b00, 3'd0);
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL mux_prep: got %h want %h", obs, e);
        end
        for (int s = 0; s < 4; s++) begin
            apply(8'h11, 8'h00, 8'h22, 1'b0, 1'b1, 2'(s), 3'(s + 1));
            n_checks++;
            if (fwd_data !== exp_tab[s]) begin
                n_fails++; $display("FAIL mux_sel%0d: got %h want %h", s, fwd_data, exp_tab[s]);
            end
            tick();
            e = pop_exp();
            n_checks++;
            if (obs !== e) begin
                n_fails++; $display("FAIL mux_reg%0d: got %h want %h", s, obs, e);
            end
        end
    endtask

    task automatic test_fwd();
        exp_t e;
        apply(8'h7E, 8'h00, 8'h00, 1'b0, 1'b1, 2'b00, 3'd5);
        n_checks++;
        if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 3'd5, 8'h7E}) begin
            n_fails++; $display("FAIL fwd: got %b/%0d/%h want 1/5/7e", fwd_valid, fwd_rd, fwd_data);
        end
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL fwd_reg: got %h want %h", obs, e);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic rw;
        // Store with reg_write set: memory and register both written.
        apply(8'h20, 8'hC3, 8'h44, 1'b1, 1'b1, 2'b00, 3'd6);
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL store_rw_reg: got %h want %h", obs, e);
        end
        for (int i = 0; i < 24; i++) begin
            rw = 1'($urandom);
            apply(8'h30 | 8'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                  1'($urandom), rw, 2'($urandom), 3'($urandom));
            n_checks++;
            if (fwd_valid !== rw) begin
                n_fails++; $display("FAIL b2b_fwd_valid%0d: got %b want %b", i, fwd_valid, rw);
            end
            tick();
            e = pop_exp();
            n_checks++;
            if (obs !== e) begin
                n_fails++; $display("FAIL b2b_reg%0d: got %h want %h", i, obs, e);
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int   cnt;
        exp_t e;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (100) tick();
        n_checks++;
        if (mem_busy !== 1'b1) begin
            n_fails++; $display("FAIL mid_clear_busy: got %b want 1", mem_busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++;
        if (obs !== 31'd0) begin
            n_fails++; $display("FAIL mid_clear_regs: got %h want 0", obs);
        end
        cnt = 0;
        while (mem_busy === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        n_checks++;
        if (cnt != 256) begin
            n_fails++; $display("FAIL mid_clear_len: got %0d cycles want 256", cnt);
        end
        model_clear();
        apply(8'h10, 8'h00, 8'h00, 1'b0, 1'b1, 2'b01, 3'd3);
        tick();
        e = pop_exp();
        n_checks++;
        if (obs !== e) begin
            n_fails++; $display("FAIL mid_clear_load: got %h want %h", obs, e);
        end
        idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_clear_store_ignored();
        test_store_load();
        test_mux_sweep();
        test_fwd();
        test_back_to_back();
        test_reset_mid_clear();
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++; $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
